// File: rtl/multi_clock_divider_if.sv
// Control and status bundle for multi_clock_divider: per-channel enables, sync,
// divisor write port and the divided outputs.
interface multi_clock_divider_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 27
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [DIV_W-1:0]  wr_div;
  logic              wr_err;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  modport master (
    output en, sync, wr_en, wr_ch, wr_div,
    input  wr_err, pend, clk_out, tick
  );

  modport slave (
    input  en, sync, wr_en, wr_ch, wr_div,
    output wr_err, pend, clk_out, tick
  );
endinterface

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider: each channel produces a ~50% duty
// waveform and a period tick, with divisor updates deferred to period boundaries.
module multi_clock_divider #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 27,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input logic                 clk_in,
  input logic                 rst,
  multi_clock_divider_if.slave bus
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DEFAULT_DIV);

  logic wr_ok;
  logic wr_err_q;

  always_comb begin
    wr_ok = bus.wr_en && (bus.wr_div >= DIV_W'(2)) && (32'(bus.wr_ch) < NUM_CH);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= bus.wr_en && !wr_ok;
    end
  end

  assign bus.wr_err = wr_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, cnt_nxt;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;

    always_comb begin
      shadow_d = (wr_ok && (bus.wr_ch == CH_W'(g))) ? bus.wr_div : shadow_q;
      cnt_nxt  = (cnt_q == active_q - DIV_W'(1)) ? '0 : cnt_q + DIV_W'(1);
      active_d = active_q;
      cnt_d    = cnt_q;
      clk_d    = 1'b0;
      tick_d   = 1'b0;
      // Every branch that reloads the active divisor uses the pre-write shadow,
      // so a write on the same edge waits for the next boundary.
      if (!bus.en[g]) begin
        active_d = shadow_q;
        cnt_d    = shadow_q - DIV_W'(1);
      end else if (bus.sync) begin
        active_d = shadow_q;
        cnt_d    = '0;
        clk_d    = 1'b1;
        tick_d   = 1'b1;
      end else begin
        cnt_d  = cnt_nxt;
        tick_d = (cnt_nxt == '0);
        if (cnt_nxt == '0) begin
          active_d = shadow_q;
        end
        clk_d = (cnt_nxt < (active_d >> 1));
      end
      pend_d = (shadow_d != active_d);
    end

    always_ff @(posedge clk_in) begin
      if (rst) begin
        shadow_q <= DefDiv;
        active_q <= DefDiv;
        cnt_q    <= DefDiv - DIV_W'(1);
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
        pend_q   <= 1'b0;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
        cnt_q    <= cnt_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
        pend_q   <= pend_d;
      end
    end

    assign bus.clk_out[g] = clk_q;
    assign bus.tick[g]    = tick_q;
    assign bus.pend[g]    = pend_q;
  end

endmodule
